sync_fifo_wr_arbiter: RTL

//   Round-robin arbiter that shares the single write port of the sync FIFO between NUM_REQ producers.

---
 rtl/sync_fifo_wr_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sync_fifo_wr_arbiter.sv
// sync_fifo_wr_arbiter
//   Round-robin arbiter that shares the single write port of a sync FIFO
//   between NUM_REQ producers. A winning producer is locked for a burst of up
//   to MAX_BURST words. The lock holds while FULL throttles the write port,
//   and every accepted word is acknowledged back to its producer.
//
// Ports
//   CLK       system clock, all state on the rising edge
//   RST       asynchronous, active-high reset
//   REQ       per-producer request, held with its data until ACK
//   REQ_DATA  producer i word in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   ACK       one-hot, producer whose word is written this cycle
//   GRANT     one-hot registered owner, 0 when idle
//   FULL      FIFO full flag
//   WR_EN     FIFO write enable
//   DATA_IN   FIFO write data (owner's word, 0 when idle)
//   BUSY      high while an owner is locked
//
// State  | meaning
// S_IDLE | no owner; arbitrate on any REQ, never write
// S_BUSY | owner locked; write its words while FIFO not full
module sync_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            ACK,
  output logic [NUM_REQ-1:0]            GRANT,
  input  logic                          FULL,
  output logic                          WR_EN,
  output logic [DATA_WIDTH-1:0]         DATA_IN,
  output logic                          BUSY
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

  logic                  owner_req;
  logic                  wr_en;
  logic                  release_a;
  logic                  last_beat;
  logic [NUM_REQ-1:0]    arb_req;
  logic                  found;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      cand_idx;
  logic [NUM_REQ-1:0]    win_onehot;
  logic [DATA_WIDTH-1:0] data_mux;

  // Write path is driven purely from the registered owner, so an async reset
  // (owner cleared, state IDLE) drops WR_EN/ACK without waiting for a clock.
  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      data_mux = data_mux | (REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{owner_q[i]}});
    end
  end

  assign owner_req = |(REQ & owner_q);
  assign wr_en     = (state_q == S_BUSY) & owner_req & ~FULL;
  assign release_a = (state_q == S_BUSY) & ~owner_req;
  assign last_beat = wr_en & (burst_cnt_q == CNT_W'(MAX_BURST - 1));

  assign WR_EN   = wr_en;
  assign ACK     = owner_q & {NUM_REQ{wr_en}};
  assign GRANT   = owner_q;
  assign DATA_IN = data_mux;
  assign BUSY    = (state_q == S_BUSY);

  // The owner bit is already clear in REQ when it dropped its request, so the
  // mask only matters for clarity; on a burst-limit release the owner stays
  // eligible, but rr_ptr points at it, which makes it lowest priority.
  assign arb_req = REQ & ~(release_a ? owner_q : '0);

  // Round-robin search starting one past the last owner.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_idx = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && arb_req[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
    win_onehot          = '0;
    win_onehot[win_idx] = found;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_BUSY;
          owner_d     = win_onehot;
          rr_ptr_d    = win_idx;
          burst_cnt_d = '0;
        end
      end
      S_BUSY: begin
        if (release_a || last_beat) begin
          burst_cnt_d = '0;
          if (found) begin
            owner_d  = win_onehot;
            rr_ptr_d = win_idx;
          end else begin
            state_d = S_IDLE;
            owner_d = '0;
          end
        end else if (wr_en) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        owner_d     = '0;
        burst_cnt_d = '0;
      end
    endcase
  end

  // rr_ptr holds the last owner; resetting it to the top index makes
  // producer 0 the first winner.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= PTR_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule
